// File: rtl/warships_pkg.sv
// -----------------------------------------------------------------------------
// warships_pkg
// Shared definitions for the board-to-board player link: payload layout,
// bit-index constants, TX/RX state encodings and the even-parity helper.
// Optional feature macro used by the link: PLAYER_LINK_PARITY_EN.
// -----------------------------------------------------------------------------
package warships_pkg;

    localparam int PAYLOAD_W            = 10;
    localparam int CORDS_LSB            = 0;
    localparam int HIT_BIT              = 8;
    localparam int READY_BIT            = 9;
    localparam int DEFAULT_CLKS_PER_BIT = 564;
    localparam int CNT_W                = 12;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Even-parity bit: makes the total count of ones (payload + bit) even.
    function automatic logic even_parity(input logic [PAYLOAD_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/player_link_rx.sv
// -----------------------------------------------------------------------------
// player_link_rx
// Receive half of the player link: 2-FF synchronizer on rx, RX frame FSM and
// the registered remote handshake outputs.
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   rx                asynchronous serial line in (idle high)
//   ready2/hit2       last valid remote ready/hit flags
//   ship_cords_in     last valid remote coordinates
//   rx_valid          one-cycle pulse when a good frame updates the outputs
//   link_err          one-cycle pulse on framing (or parity) error
// Optional: PLAYER_LINK_PARITY_EN adds an even-parity bit before stop.
// -----------------------------------------------------------------------------
module player_link_rx
    import warships_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       ready2,
    output logic       hit2,
    output logic [7:0] ship_cords_in,
    output logic       rx_valid,
    output logic       link_err
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(PAYLOAD_W - 1);

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;   // parity mismatch seen in this frame
    logic                 ready2_q, ready2_d;
    logic                 hit2_q, hit2_d;
    logic [7:0]           cords_q, cords_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    assign rx_s = sync2_q;

    // RX frame FSM next-state and output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 12'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ready2_d = ready2_q;
        hit2_d   = hit2_q;
        cords_d  = cords_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d  = 12'd0;
                bit_d  = 4'd0;
                perr_d = 1'b0;
                if (!rx_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                // Re-check at mid start bit; a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 12'd0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    shift_d = {rx_s, shift_q[PAYLOAD_W-1:1]};   // LSB first
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef PLAYER_LINK_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    perr_d  = rx_s ^ even_parity(shift_q);
                    state_d = RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 12'd0;
                    if (!rx_s) begin
                        err_d   = 1'b1;
                        state_d = RX_BREAK;
                    end else if (perr_q) begin
                        err_d   = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ready2_d = shift_q[READY_BIT];
                        hit2_d   = shift_q[HIT_BIT];
                        cords_d  = shift_q[CORDS_LSB +: 8];
                        valid_d  = 1'b1;
                        state_d  = RX_IDLE;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_BREAK: begin
                // Line held low past the stop bit: wait for it to recover.
                cnt_d = 12'd0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                cnt_d   = 12'd0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // Synchronizer and RX state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= RX_IDLE;
            cnt_q    <= 12'd0;
            bit_q    <= 4'd0;
            shift_q  <= 10'd0;
            perr_q   <= 1'b0;
            ready2_q <= 1'b0;
            hit2_q   <= 1'b0;
            cords_q  <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ready2_q <= ready2_d;
            hit2_q   <= hit2_d;
            cords_q  <= cords_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ready2        = ready2_q;
    assign hit2          = hit2_q;
    assign ship_cords_in = cords_q;
    assign rx_valid      = valid_q;
    assign link_err      = err_q;

endmodule

// File: rtl/player_link.sv
// -----------------------------------------------------------------------------
// player_link
// Serial link between the two game boards. Sends the local FSM handshake
// {ready1, hit1, ship_cords_out} as a UART-style frame whenever it differs
// from the last value sent, and receives the opponent's frames through
// player_link_rx.
// Frame: start(0), 10 payload bits LSB first, [even parity], stop(1).
// Ports:
//   clk, rst                 system clock, synchronous active-low reset
//   ready1, hit1, ship_cords_out   local values to transmit
//   ready2, hit2, ship_cords_in    last valid remote values
//   tx / rx                  serial line out (idle high) / in (asynchronous)
//   rx_valid, link_err       one-cycle receive status pulses
// Optional: define PLAYER_LINK_PARITY_EN for the parity bit (13-bit frame).
// -----------------------------------------------------------------------------
module player_link
    import warships_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready1,
    input  logic       hit1,
    input  logic [7:0] ship_cords_out,
    output logic       ready2,
    output logic       hit2,
    output logic [7:0] ship_cords_in,
    output logic       tx,
    input  logic       rx,
    output logic       rx_valid,
    output logic       link_err
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(PAYLOAD_W - 1);

    logic [PAYLOAD_W-1:0] payload_s;
    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic [PAYLOAD_W-1:0] last_q, last_d;
    logic                 tx_q, tx_d;

    // Pack the local handshake into the payload layout.
    always_comb begin
        payload_s                  = 10'd0;
        payload_s[CORDS_LSB +: 8]  = ship_cords_out;
        payload_s[HIT_BIT]         = hit1;
        payload_s[READY_BIT]       = ready1;
    end

    // TX frame FSM: tx_d is the line level for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 12'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = 12'd0;
                bit_d = 4'd0;
                // Only the value present when idle is compared, so changes
                // made during a frame collapse into the latest one.
                if (payload_s != last_q) begin
                    shift_d = payload_s;
                    last_d  = payload_s;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    shift_d = {1'b0, shift_q[PAYLOAD_W-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef PLAYER_LINK_PARITY_EN
                        tx_d    = even_parity(last_q);
                        state_d = TX_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
`endif
                    end else begin
                        tx_d    = shift_q[1];
                        state_d = TX_DATA;
                    end
                end else begin
                    state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    tx_d    = 1'b1;
                    state_d = TX_STOP;
                end else begin
                    state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                // Always passes through TX_IDLE, giving at least one idle cycle.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 12'd0;
                    tx_d    = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_STOP;
                end
            end
            default: begin
                cnt_d   = 12'd0;
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // TX state registers; reset aborts any frame and returns tx high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= 12'd0;
            bit_q   <= 4'd0;
            shift_q <= 10'd0;
            last_q  <= 10'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

    player_link_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .ready2        (ready2),
        .hit2          (hit2),
        .ship_cords_in (ship_cords_in),
        .rx_valid      (rx_valid),
        .link_err      (link_err)
    );

endmodule
